// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM encoding and ASCII range.
// Used by the receiver, the transmitter and the ASCII ROM.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int OVERSAMPLING   = 16;

  // Tick indices inside one bit period (counted from 0).
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLING / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLING - 1);

  localparam logic [7:0] ASCII_FIRST = 8'd32;
  localparam logic [7:0] ASCII_LAST  = 8'd126;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_FIRST) && (b <= ASCII_LAST);
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversampling tick generator: one-clock tick every DIV clocks, restartable via clear.
// Shared between the UART receiver and transmitter.
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling, start/data/stop deframing
// with a one-cycle valid strobe, framing-error pulse and printable-ASCII qualifier.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_printable,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLING);

  rx_state_t r_state, w_state_next;

  logic       r_sync1, r_rxs, r_rxs_d;
  logic       w_fall, w_tick, w_clear;

  logic [3:0] r_tick_cnt, w_tick_cnt_next;
  logic [2:0] r_bit_idx, w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [UART_DATA_BITS-1:0] r_data, w_data_next;
  logic       r_valid, w_valid_next;
  logic       r_printable, w_printable_next;
  logic       r_frame_err, w_frame_err_next;

  // Synchroniser idles high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_fall = r_rxs_d & ~r_rxs;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_printable <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_printable <= w_printable_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_tick_cnt_next  = r_tick_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_printable_next = 1'b0;
    w_frame_err_next = 1'b0;
    w_clear          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next    = ST_START;
          w_tick_cnt_next = '0;
          w_clear         = 1'b1;
        end
      end

      // Half a bit in: a line already back high was only a glitch.
      ST_START: begin
        if (w_tick) begin
          if (r_tick_cnt == MID_TICK) begin
            w_tick_cnt_next = '0;
            if (!r_rxs) begin
              w_state_next   = ST_DATA;
              w_bit_idx_next = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (r_tick_cnt == LAST_TICK) begin
            w_shift_next   = {r_rxs, r_shift[UART_DATA_BITS-1:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_state_next = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (r_tick_cnt == LAST_TICK) begin
            if (r_rxs) begin
              w_data_next      = r_shift;
              w_valid_next     = 1'b1;
              w_printable_next = is_printable(r_shift);
              w_state_next     = ST_IDLE;
            end else begin
              w_frame_err_next = 1'b1;
              w_state_next     = ST_BREAK;
            end
          end
        end
      end

      // Hold off new frames until a line break ends.
      ST_BREAK: begin
        if (r_rxs) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_printable = r_printable;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule
